// File: rtl/spi_pkg.sv
// spi_pkg: shared types and widths for the SPI master driver slice.
//   opcode_e : RAM command opcodes carried in cmd_word[9:8]
//   state_e  : frame sequencer states of spi_master_driver
//   CMD_W    : command word width (opcode + payload)
//   DATA_W   : read-back byte width
package spi_pkg;

    localparam int unsigned CMD_W  = 10;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        FLAG   = 3'd2,
        SHIFT  = 3'd3,
        TURN   = 3'd4,
        RECV   = 3'd5,
        DONE   = 3'd6
    } state_e;

endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: 10-bit parallel-load / serial-out transmit register plus
// 8-bit serial-in receive register, both MSB first.
//   clk, rst_n    : clock, asynchronous active-low reset
//   load_i        : load load_data_i into the transmit register
//   load_data_i   : command word to transmit
//   shift_i       : shift transmit register left by one
//   sample_i      : shift sin_i into the receive register
//   sin_i         : serial input (MISO)
//   sout_o        : current transmit MSB
//   sout_next_o   : transmit bit that becomes MSB after the next shift
//   rx_data_o     : receive register contents
module spi_shift_reg
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [CMD_W-1:0]  load_data_i,
    input  logic              shift_i,
    input  logic              sample_i,
    input  logic              sin_i,
    output logic              sout_o,
    output logic              sout_next_o,
    output logic [DATA_W-1:0] rx_data_o
);

    logic [CMD_W-1:0]  tx_q;
    logic [DATA_W-1:0] rx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= '0;
        end else if (load_i) begin
            tx_q <= load_data_i;
        end else if (shift_i) begin
            tx_q <= {tx_q[CMD_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q <= '0;
        end else if (sample_i) begin
            rx_q <= {rx_q[DATA_W-2:0], sin_i};
        end
    end

    assign sout_o      = tx_q[CMD_W-1];
    assign sout_next_o = tx_q[CMD_W-2];
    assign rx_data_o   = rx_q;

endmodule

// File: rtl/spi_master_driver.sv
// spi_master_driver: SPI initiator for the SPI slave + RAM subsystem.
// Accepts 10-bit command words over valid/ready, sends SELECT, FLAG and 10
// data bits MSB first under SS_n; RD_DATA frames add RD_LATENCY turnaround
// cycles and capture 8 MISO bits MSB first.
//   clk, rst_n          : clock (also SPI bit clock), async active-low reset
//   cmd_valid/cmd_ready : command handshake, cmd_word = {opcode, payload}
//   SS_n, MOSI, MISO    : SPI lines
//   rd_data, rd_valid   : captured read byte, one-cycle update pulse
//   busy                : frame in progress (SS_n low)
//   cmd_err             : one-cycle pulse for a command rejected by order check
// Build option: SPI_MASTER_ORDER_CHECK_EN enables command-order checking
// (WR_DATA needs a prior WR_ADDR, RD_DATA a prior RD_ADDR); otherwise
// every command is forwarded and cmd_err stays 0.
module spi_master_driver
    import spi_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [CMD_W-1:0]  cmd_word,
    output logic              cmd_ready,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              cmd_err
);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                rd_op_q, rd_op_d;
    logic                ss_n_q, ss_n_d;
    logic                mosi_q, mosi_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                err_q, err_d;

    logic                accept, legal, load, shift, sample;
    logic                sout, sout_next;
    logic [DATA_W-1:0]   rx_data;
    opcode_e             op;

    assign op     = opcode_e'(cmd_word[CMD_W-1:CMD_W-2]);
    assign accept = cmd_valid & ready_q;

`ifdef SPI_MASTER_ORDER_CHECK_EN
    logic wr_seen_q, rd_seen_q;

    assign legal = !((op == WR_DATA) && !wr_seen_q) &&
                   !((op == RD_DATA) && !rd_seen_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_seen_q <= 1'b0;
            rd_seen_q <= 1'b0;
        end else if (accept && legal) begin
            if (op == WR_ADDR) wr_seen_q <= 1'b1;
            if (op == RD_ADDR) rd_seen_q <= 1'b1;
        end
    end
`else
    assign legal = 1'b1;
`endif

    spi_shift_reg u_shift_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load),
        .load_data_i (cmd_word),
        .shift_i     (shift),
        .sample_i    (sample),
        .sin_i       (MISO),
        .sout_o      (sout),
        .sout_next_o (sout_next),
        .rx_data_o   (rx_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_op_d    = rd_op_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        sample     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    if (legal) begin
                        load    = 1'b1;
                        rd_op_d = (op == RD_DATA);
                        state_d = SELECT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SELECT: state_d = FLAG;
            FLAG: begin
                state_d = SHIFT;
                cnt_d   = '0;
            end
            SHIFT: begin
                shift = 1'b1;
                if (cnt_q == 4'd9) begin
                    cnt_d   = '0;
                    state_d = rd_op_q ? TURN : DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            TURN: begin
                if (cnt_q == 4'(RD_LATENCY - 1)) begin
                    cnt_d   = '0;
                    state_d = RECV;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RECV: begin
                sample = 1'b1;
                if (cnt_q == 4'd7) begin
                    state_d    = DONE;
                    rd_valid_d = 1'b1;
                    rd_data_d  = {rx_data[DATA_W-2:0], MISO};
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so every pin changes on the
    // same edge as the state it belongs to. The first SHIFT bit repeats the
    // unshifted MSB (same bit as FLAG); later bits take the bit that the
    // concurrent shift moves into the MSB.
    always_comb begin
        ss_n_d  = (state_d == IDLE) || (state_d == DONE);
        ready_d = ss_n_d;
        mosi_d  = 1'b0;
        if (state_d == FLAG) begin
            mosi_d = sout;
        end else if (state_d == SHIFT) begin
            mosi_d = (state_q == FLAG) ? sout : sout_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_op_q    <= 1'b0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            ready_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_op_q    <= rd_op_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            ready_q    <= ready_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    assign cmd_ready = ready_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign busy      = ~ss_n_q;
    assign cmd_err   = err_q;

endmodule

// File: tb/tb_spi_master_driver.sv
module tb_spi_master_driver;

    localparam int unsigned RD_LAT = 2;
`ifdef SPI_MASTER_ORDER_CHECK_EN
    localparam bit ORDER_CHK = 1'b1;
`else
    localparam bit ORDER_CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic [9:0] cmd_word;
    logic       cmd_ready;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       cmd_err;

    spi_master_driver #(.RD_LATENCY(RD_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_word  (cmd_word),
        .cmd_ready (cmd_ready),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Slave/RAM reference model
    logic [7:0] ram [256];
    logic [7:0] wa, ra;
    bit         wa_seen, ra_seen;
    logic [7:0] last_rd;

    // SS_n high-run monitor
    int unsigned hi_run   = 0;
    int unsigned last_gap = 0;
    always @(negedge clk) begin
        if (SS_n === 1'b1) begin
            hi_run++;
        end else begin
            if (hi_run != 0) last_gap = hi_run;
            hi_run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {SS_n, MOSI, cmd_ready, rd_valid, busy, cmd_err, rd_data},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    endtask

    // Issue one command starting at a negedge; returns at the negedge of the
    // first cycle after the frame (or after the cmd_err pulse).
    task automatic do_cmd(input logic [9:0] w, input bit hold, output logic [31:0] mosi_obs);
        bit          legal, is_rd;
        int unsigned n, waitc, lowc, busyc, errc, rdvc, rdyc;
        logic [7:0]  rbyte;
        logic [31:0] mexp;
        logic        ebit;
        legal = !(ORDER_CHK && (((w[9:8] == 2'b01) && !wa_seen) ||
                                ((w[9:8] == 2'b11) && !ra_seen)));
        mosi_obs  = '0;
        cmd_valid = 1'b1;
        cmd_word  = w;
        waitc     = 0;
        while (cmd_ready !== 1'b1 && waitc < 40) begin
            @(negedge clk);
            waitc++;
        end
        if (cmd_ready !== 1'b1) begin
            check("handshake_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        cmd_word = 10'($urandom);
        if (!hold || !legal) cmd_valid = 1'b0;

        if (!legal) begin
            @(negedge clk);
            check("err_pulse", cmd_err, 1);
            check("err_no_frame", {SS_n, cmd_ready, rd_valid}, 3'b110);
            @(negedge clk);
            check("err_clear", {cmd_err, SS_n}, 2'b01);
            return;
        end

        is_rd = (w[9:8] == 2'b11);
        n     = is_rd ? 20 + RD_LAT : 12;
        rbyte = ram[ra];
        mexp  = '0;
        lowc = 0; busyc = 0; errc = 0; rdvc = 0; rdyc = 0;
        for (int unsigned i = 1; i <= n; i++) begin
            @(negedge clk);
            if (SS_n === 1'b0) lowc++;
            if (busy !== ~SS_n) busyc++;
            if (cmd_err !== 1'b0) errc++;
            if (rd_valid !== 1'b0) rdvc++;
            if (cmd_ready !== 1'b0) rdyc++;
            mosi_obs = {mosi_obs[30:0], MOSI};
            ebit = 1'b0;
            if (i == 2) ebit = w[9];
            else if (i >= 3 && i <= 12) ebit = w[12-i];
            mexp = {mexp[30:0], ebit};
            if (i >= 13 + RD_LAT && i <= 20 + RD_LAT) MISO = rbyte[20+RD_LAT-i];
            else MISO = 1'($urandom);
        end
        @(negedge clk);
        MISO = 1'($urandom);
        check("ss_low_cycles", lowc, n);
        check("frame_end", {SS_n, cmd_ready, busy}, 3'b110);
        check("mosi_bits", mosi_obs, mexp);
        check("in_frame_flags", {busyc[7:0], errc[7:0], rdvc[7:0], rdyc[7:0]}, 32'd0);
        check("rd_valid_end", rd_valid, is_rd);
        if (is_rd) last_rd = rbyte;
        check("rd_data", rd_data, last_rd);
        cmd_valid = 1'b0;

        case (w[9:8])
            2'b00: begin wa = w[7:0]; wa_seen = 1'b1; end
            2'b01: ram[wa] = w[7:0];
            2'b10: begin ra = w[7:0]; ra_seen = 1'b1; end
            default: ;
        endcase
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [9:0]  w;
        bit          hold;

        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
        wa = '0; ra = '0; wa_seen = 1'b0; ra_seen = 1'b0; last_rd = '0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_word = '0; MISO = 1'b0;

        // Reset
        repeat (5) @(negedge clk);
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", cmd_ready, 0);
        @(posedge clk);
        #1;
        check("ready_after_edge", cmd_ready, 1);
        @(negedge clk);

        // RD_DATA first: rejected with order check, full frame otherwise
        do_cmd(10'h3C7, 1'b0, v);
        @(negedge clk);

        // Directed WR_ADDR 0x005 bit pattern, then back-to-back WR_DATA
        do_cmd(10'h005, 1'b1, v);
        check("wr_addr_005_mosi", v[11:0], 12'h005);
        do_cmd(10'h1A5, 1'b1, v);
        check("b2b_gap", last_gap, 1);
        @(negedge clk);

        // RD_ADDR 0x05 then RD_DATA returns the byte written above
        do_cmd(10'h205, 1'b0, v);
        repeat (2) @(negedge clk);
        do_cmd(10'h300, 1'b0, v);
        check("rd_data_A5", rd_data, 8'hA5);

        // Reset during SHIFT bit 5
        cmd_valid = 1'b1;
        cmd_word  = 10'h0AA;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_frame_busy", SS_n, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_frame_reset");
        repeat (2) @(negedge clk);
        check_reset_outputs("mid_frame_reset_hold");
        rst_n   = 1'b1;
        wa_seen = 1'b0;
        ra_seen = 1'b0;
        last_rd = '0;
        @(negedge clk);
        do_cmd(10'h0C3, 1'b0, v);
        check("post_reset_mosi", v[11:0], 12'h0C3);

        // Randomised traffic
        repeat (60) begin
            w    = 10'($urandom);
            hold = 1'($urandom);
            do_cmd(w, hold, v);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
